// File: rtl/bomb_sched_if.sv
// Player request / bomb-map bus bundle between the player input logic,
// the bomb_sched controller (slave) and the map storage / player side (master).
interface bomb_sched_if;
  logic       req_a;
  logic [3:0] ax;
  logic [3:0] ay;
  logic       req_b;
  logic [3:0] bx;
  logic [3:0] by;
  logic       tick_req;
  logic       expl_a;
  logic       expl_b;
  logic [6:0] map_rd_addr;
  logic [1:0] map_rd_data;
  logic       map_wr_en;
  logic [6:0] map_wr_addr;
  logic [1:0] map_wr_data;
  logic       map_step;
  logic       ack_a;
  logic       ack_b;
  logic       nack_a;
  logic       nack_b;
  logic [2:0] cnt_a;
  logic [2:0] cnt_b;
  logic       busy;

  modport slave (
    input  req_a, ax, ay, req_b, bx, by, tick_req, expl_a, expl_b, map_rd_data,
    output map_rd_addr, map_wr_en, map_wr_addr, map_wr_data, map_step,
           ack_a, ack_b, nack_a, nack_b, cnt_a, cnt_b, busy
  );

  modport master (
    output req_a, ax, ay, req_b, bx, by, tick_req, expl_a, expl_b, map_rd_data,
    input  map_rd_addr, map_wr_en, map_wr_addr, map_wr_data, map_step,
           ack_a, ack_b, nack_a, nack_b, cnt_a, cnt_b, busy
  );
endinterface

// File: rtl/bomb_sched.sv
// Bomb placement scheduler: round-robin arbitration of two players, cell/limit check,
// bomb write and map-advance scheduling. Optional per-player cooldown: BOMB_SCHED_COOLDOWN_EN.
module bomb_sched #(
  parameter int MAX_BOMBS = 3
`ifdef BOMB_SCHED_COOLDOWN_EN
  ,
  parameter int COOLDOWN  = 8
`endif
) (
  input logic          clk,
  input logic          rst,
  bomb_sched_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, STEP, RD, CHK, WR} state_t;

  localparam logic [2:0] MAX_C = 3'(MAX_BOMBS);

  state_t          state_q;
  logic            tick_pend_q;
  logic            ptr_q;        // 0: A favoured on a tie, 1: B favoured
  logic            own_q;        // 0: A, 1: B
  logic [6:0]      addr_q;
  logic [6:0]      rd_addr_q;
  logic [6:0]      wr_addr_q;
  logic            wr_en_q;
  logic [1:0]      wr_data_q;
  logic            step_q;
  logic [1:0]      ack_q;
  logic [1:0]      nack_q;
  logic            busy_q;
  logic [1:0][2:0] cnt_q;

  logic [1:0] req_v;
  logic [1:0] cool_blk;
  logic [1:0] elig;
  logic [1:0] cool_nack;
  logic [1:0] expl;
  logic [1:0] inc;
  logic       sel;
  logic [3:0] sel_x;
  logic [3:0] sel_y;
  logic       coord_ok;
  logic [6:0] sel_addr;
  logic       chk_ok;
  logic       accept;

  // A requester still showing its ack/nack is holding req from the finished transaction.
  assign req_v     = {bus.req_b, bus.req_a} & ~ack_q & ~nack_q;
  assign elig      = req_v & ~cool_blk;
  assign cool_nack = (state_q == IDLE) ? (req_v & cool_blk) : 2'b00;
  assign sel       = (elig == 2'b11) ? ptr_q : elig[1];
  assign sel_x     = sel ? bus.bx : bus.ax;
  assign sel_y     = sel ? bus.by : bus.ay;
  assign coord_ok  = (sel_x != 4'd0) && (sel_x <= 4'd8) && (sel_y != 4'd0) && (sel_y <= 4'd8);
  assign sel_addr  = {3'b000, sel_x} * 7'd10 + {3'b000, sel_y};
  assign chk_ok    = (bus.map_rd_data == 2'd0) && (cnt_q[own_q] != MAX_C);
  assign accept    = (state_q == CHK) && chk_ok;
  assign inc       = accept ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  assign expl      = {bus.expl_b, bus.expl_a};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_pend_q <= 1'b0;
      ptr_q       <= 1'b0;
      own_q       <= 1'b0;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      step_q      <= 1'b0;
      ack_q       <= '0;
      nack_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      step_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      ack_q     <= '0;
      nack_q    <= cool_nack;

      // Repeated ticks collapse into the single pending flag; a new tick always wins.
      if (bus.tick_req) begin
        tick_pend_q <= 1'b1;
      end else if (state_q == IDLE && tick_pend_q) begin
        tick_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (tick_pend_q) begin
            step_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= STEP;
          end else if (|elig) begin
            ptr_q <= ~sel;
            if (coord_ok) begin
              own_q     <= sel;
              addr_q    <= sel_addr;
              rd_addr_q <= sel_addr;
              busy_q    <= 1'b1;
              state_q   <= RD;
            end else begin
              nack_q[sel] <= 1'b1;
            end
          end
        end
        STEP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        RD: begin
          busy_q  <= 1'b1;
          state_q <= CHK;
        end
        CHK: begin
          if (chk_ok) begin
            wr_en_q       <= 1'b1;
            wr_addr_q     <= addr_q;
            wr_data_q     <= 2'd1;
            ack_q[own_q]  <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= WR;
          end else begin
            nack_q[own_q] <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        WR: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Live bomb counters: a placement and an explosion in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (inc[p] && !expl[p]) begin
          cnt_q[p] <= cnt_q[p] + 3'd1;
        end else if (!inc[p] && expl[p] && cnt_q[p] != 3'd0) begin
          cnt_q[p] <= cnt_q[p] - 3'd1;
        end
      end
    end
  end

`ifdef BOMB_SCHED_COOLDOWN_EN
  localparam int CW = $clog2(COOLDOWN + 1);

  logic [1:0][CW-1:0] cool_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cool_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (inc[p]) begin
          cool_q[p] <= CW'(COOLDOWN);
        end else if (cool_q[p] != '0) begin
          cool_q[p] <= cool_q[p] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    cool_blk = 2'b00;
    for (int p = 0; p < 2; p++) begin
      cool_blk[p] = (cool_q[p] != '0);
    end
  end
`else
  assign cool_blk = 2'b00;
`endif

  assign bus.map_rd_addr = rd_addr_q;
  assign bus.map_wr_en   = wr_en_q;
  assign bus.map_wr_addr = wr_addr_q;
  assign bus.map_wr_data = wr_data_q;
  assign bus.map_step    = step_q;
  assign bus.ack_a       = ack_q[0];
  assign bus.ack_b       = ack_q[1];
  assign bus.nack_a      = nack_q[0];
  assign bus.nack_b      = nack_q[1];
  assign bus.cnt_a       = cnt_q[0];
  assign bus.cnt_b       = cnt_q[1];
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bomb_sched.sv
// Randomized bench for bomb_sched: a transaction-timeline model predicts every output one
// cycle ahead; a small map storage and bomb-datapath stand-in sit around the DUT.
module tb_bomb_sched;
  localparam int MAX_BOMBS = 3;
  localparam int N         = 3000;
`ifdef BOMB_SCHED_COOLDOWN_EN
  localparam int COOLDOWN  = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bomb_sched_if bif();
  bomb_sched #(.MAX_BOMBS(MAX_BOMBS)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

  int errs   = 0;
  int checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Map storage: synchronous read, written by the DUT.
  logic [1:0] mem  [128];
  logic [1:0] mmem [128];
  always @(posedge clk) begin
    if (bif.map_wr_en) mem[bif.map_wr_addr] <= bif.map_wr_data;
    bif.map_rd_data <= mem[bif.map_rd_addr];
  end

  typedef struct packed {
    logic [1:0] ack;
    logic [1:0] nack;
    logic       step;
    logic       wr_en;
    logic       busy;
    logic [6:0] rd_addr;
    logic [6:0] wr_addr;
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;
  } exp_t;

  exp_t cur, nxt;

  // Model: scheduler timeline (when the controller is next free, when a check is due).
  int         free_at  = 0;
  int         chk_at   = -1;
  int         t_owner  = 0;
  int         t_addr   = 0;
  bit         mpend    = 0;
  int         ptr      = 0;
  int         mcnt [2] = '{0, 0};
  int         cool_end [2] = '{-100, -100};

  logic [1:0] rq;
  logic [1:0] hold;
  logic [1:0] resp_seen;
  logic [3:0] px [2];
  logic [3:0] py [2];
  logic       tk;
  logic [1:0] ex;

  function automatic logic [3:0] rnd_coord();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 12) return 4'(1 + (r % 8));
    if (r == 13) return 4'd0;
    return 4'($urandom_range(9, 15));
  endfunction

  task automatic model_step(int k);
    logic [1:0] elig;
    logic [1:0] inc;
    bit         stepped;
    int         sel;
    nxt         = '0;
    nxt.rd_addr = cur.rd_addr;
    inc         = 2'b00;
    stepped     = 0;
    if (k == chk_at) begin
      chk_at = -1;
      if (mmem[t_addr] != 2'd0 || mcnt[t_owner] == MAX_BOMBS) begin
        nxt.nack[t_owner] = 1'b1;
        free_at = k + 1;
      end else begin
        nxt.ack[t_owner] = 1'b1;
        nxt.wr_en        = 1'b1;
        nxt.wr_addr      = 7'(t_addr);
        mmem[t_addr]     = 2'd1;
        inc[t_owner]     = 1'b1;
        free_at          = k + 2;
`ifdef BOMB_SCHED_COOLDOWN_EN
        cool_end[t_owner] = k + 1 + COOLDOWN;
`endif
      end
    end
    if (k >= free_at) begin
      for (int p = 0; p < 2; p++) begin
        elig[p] = rq[p] && !cur.ack[p] && !cur.nack[p];
        if (elig[p] && k < cool_end[p]) begin
          nxt.nack[p] = 1'b1;
          elig[p]     = 1'b0;
        end
      end
      if (mpend) begin
        nxt.step = 1'b1;
        stepped  = 1;
        free_at  = k + 2;
      end else if (elig != 2'b00) begin
        sel = (elig == 2'b11) ? ptr : (elig[1] ? 1 : 0);
        ptr = 1 - sel;
        if (px[sel] >= 1 && px[sel] <= 8 && py[sel] >= 1 && py[sel] <= 8) begin
          t_owner     = sel;
          t_addr      = 10 * int'(px[sel]) + int'(py[sel]);
          nxt.rd_addr = 7'(t_addr);
          chk_at      = k + 2;
          free_at     = k + 1000;
        end else begin
          nxt.nack[sel] = 1'b1;
          free_at       = k + 1;
        end
      end
    end
    mpend = tk || (mpend && !stepped);
    for (int p = 0; p < 2; p++) begin
      if (inc[p] && !ex[p]) mcnt[p]++;
      else if (!inc[p] && ex[p] && mcnt[p] > 0) mcnt[p]--;
    end
    nxt.cnt_a = 3'(mcnt[0]);
    nxt.cnt_b = 3'(mcnt[1]);
    nxt.busy  = (k + 1 < free_at);
  endtask

  task automatic compare();
    check("ack_a", bif.ack_a, cur.ack[0]);
    check("ack_b", bif.ack_b, cur.ack[1]);
    check("nack_a", bif.nack_a, cur.nack[0]);
    check("nack_b", bif.nack_b, cur.nack[1]);
    check("map_step", bif.map_step, cur.step);
    check("map_wr_en", bif.map_wr_en, cur.wr_en);
    check("busy", bif.busy, cur.busy);
    check("map_rd_addr", bif.map_rd_addr, cur.rd_addr);
    check("cnt_a", bif.cnt_a, cur.cnt_a);
    check("cnt_b", bif.cnt_b, cur.cnt_b);
    check("step_wr_overlap", bif.map_step & bif.map_wr_en, 0);
    if (cur.wr_en) begin
      check("map_wr_addr", bif.map_wr_addr, cur.wr_addr);
      check("map_wr_data", bif.map_wr_data, 1);
    end
  endtask

  task automatic literal_checks(int k);
    case (k)
      0: begin
        check("lit_rst_rd_addr", bif.map_rd_addr, 0);
        check("lit_rst_busy", bif.busy, 0);
        check("lit_rst_cnt_a", bif.cnt_a, 0);
        check("lit_rst_step", bif.map_step, 0);
      end
      2: begin
        check("lit_rd_addr_34", bif.map_rd_addr, 34);
        check("lit_busy_rd", bif.busy, 1);
      end
      4: begin
        check("lit_wr_en", bif.map_wr_en, 1);
        check("lit_wr_addr_34", bif.map_wr_addr, 34);
        check("lit_wr_data", bif.map_wr_data, 1);
        check("lit_ack_a", bif.ack_a, 1);
        check("lit_cnt_a_1", bif.cnt_a, 1);
      end
      10: begin
        check("lit_nack_a_occupied", bif.nack_a, 1);
        check("lit_no_wr_occupied", bif.map_wr_en, 0);
        check("lit_cnt_a_kept", bif.cnt_a, 1);
      end
      13: begin
        check("lit_nack_a_range", bif.nack_a, 1);
        check("lit_busy_range", bif.busy, 0);
        check("lit_no_read_range", bif.map_rd_addr, 55);
      end
      default: ;
    endcase
  endtask

  initial begin
    int a;
    logic [1:0] v;
    bit start;
    for (int i = 0; i < 128; i++) begin
      mem[i]  = 2'd0;
      mmem[i] = 2'd0;
    end
    for (int i = 0; i < 8; i++) begin
      a = 10 * $urandom_range(1, 8) + $urandom_range(1, 8);
      if (a != 34) begin
        mem[a]  = 2'd2;
        mmem[a] = 2'd2;
      end
    end
    mem[55] = 2'd2;
    mmem[55] = 2'd2;
    bif.map_rd_data = 2'd0;
    bif.req_a = 0; bif.ax = 0; bif.ay = 0;
    bif.req_b = 0; bif.bx = 0; bif.by = 0;
    bif.tick_req = 0; bif.expl_a = 0; bif.expl_b = 0;
    rq = '0; hold = '0; resp_seen = '0;
    px[0] = 0; py[0] = 0; px[1] = 0; py[1] = 0;
    cur = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      compare();
      literal_checks(k);
      // Bomb datapath stand-in: each map advance clears and changes a few cells.
      if (cur.step) begin
        for (int i = 0; i < 2; i++) begin
          a = $urandom_range(0, 127);
          mem[a] = 2'd0; mmem[a] = 2'd0;
        end
        a = 10 * $urandom_range(1, 8) + $urandom_range(1, 8);
        v = 2'($urandom_range(0, 3));
        mem[a] = v; mmem[a] = v;
      end
      for (int p = 0; p < 2; p++) begin
        if (k < 20) begin
          start = (p == 0) && (k == 1 || k == 7 || k == 12);
        end else if (k < N - 30) begin
          start = ($urandom_range(0, 2) == 0);
        end else begin
          start = 0;
        end
        if (resp_seen[p]) begin
          rq[p] = 1'b0;
          hold[p] = 1'b0;
        end else if (!hold[p] && !rq[p] && start) begin
          hold[p] = 1'b1;
          rq[p] = 1'b1;
          if (k == 1)       begin px[p] = 4'd3; py[p] = 4'd4; end
          else if (k == 7)  begin px[p] = 4'd5; py[p] = 4'd5; end
          else if (k == 12) begin px[p] = 4'd9; py[p] = 4'd1; end
          else begin px[p] = rnd_coord(); py[p] = rnd_coord(); end
        end
        resp_seen[p] = cur.ack[p] | cur.nack[p];
      end
      if (k >= 20 && k < N - 30) begin
        tk    = ($urandom_range(0, 9) == 0);
        ex[0] = ($urandom_range(0, 19) == 0);
        ex[1] = ($urandom_range(0, 19) == 0);
      end else begin
        tk = 1'b0;
        ex = 2'b00;
      end
      bif.req_a = rq[0]; bif.ax = px[0]; bif.ay = py[0];
      bif.req_b = rq[1]; bif.bx = px[1]; bif.by = py[1];
      bif.tick_req = tk; bif.expl_a = ex[0]; bif.expl_b = ex[1];
      model_step(k);
      cur = nxt;
    end

    // Asynchronous reset: outputs clear without waiting for a clock edge.
    bif.req_a = 0; bif.req_b = 0; bif.tick_req = 0; bif.expl_a = 0; bif.expl_b = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", bif.busy, 0);
    check("async_rst_cnt_a", bif.cnt_a, 0);
    check("async_rst_cnt_b", bif.cnt_b, 0);
    #1 rst = 1'b0;
    mem[11] = 2'd0;
    bif.req_a = 1; bif.ax = 4'd1; bif.ay = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    check("wr_before_rst", bif.map_wr_en, 1);
    check("wr_addr_before_rst", bif.map_wr_addr, 11);
    check("ack_before_rst", bif.ack_a, 1);
    rst = 1'b1;
    #1;
    check("wr_cleared_by_rst", bif.map_wr_en, 0);
    check("ack_cleared_by_rst", bif.ack_a, 0);
    check("busy_cleared_by_rst", bif.busy, 0);
    bif.req_a = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
